sfu_job_ctrl: RTL and testbench

Job controller sitting directly upstream of finish_gen in the SFU datapath. Accepts a job start with a beat count, drives finish_gen's enable/clear/total_num, waits for its finish, then raises a done pulse and a sticky interrupt. Owns the per-job sequencing (clear, arm, run, complete, abort) so finish_gen remains a pure counter.

---
 rtl/sfu_job_pkg.sv | 19 +
 rtl/sfu_job_ctrl_if.sv | 37 +++
 rtl/sfu_job_watchdog.sv | 38 +++
 rtl/sfu_job_ctrl.sv | 144 ++++++++++++++
 tb/tb_sfu_job_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sfu_job_pkg.sv
// sfu_job_pkg: shared types and defaults for the SFU job controller.
//   state_t            : job sequencing states (IDLE, CLEAR, ARM, RUN, DONE)
//   NUM_W_DEF          : default width of beat count / total_num
//   TIMEOUT_CYCLES_DEF : default watchdog limit in RUN cycles
//                        (only meaningful when SFU_JOB_TIMEOUT_EN is defined)
package sfu_job_pkg;

   localparam int          NUM_W_DEF          = 32;
   localparam logic [31:0] TIMEOUT_CYCLES_DEF = 32'd1_000_000;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ARM,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/sfu_job_ctrl_if.sv
// sfu_job_ctrl_if: handshake bundle between the job host / finish_gen and
// the job controller.
//   host -> ctrl      : start, cfg_num, abort, irq_clr
//   finish_gen -> ctrl: finish
//   ctrl -> finish_gen: enable, clear, total_num
//   ctrl -> host      : busy, done_pulse, irq, err
// modport slave is the controller view; modport master is the environment.
interface sfu_job_ctrl_if
   import sfu_job_pkg::*;
#(
   parameter int NUM_W = NUM_W_DEF
);

   logic             start;
   logic [NUM_W-1:0] cfg_num;
   logic             abort;
   logic             irq_clr;
   logic             finish;
   logic             enable;
   logic             clear;
   logic [NUM_W-1:0] total_num;
   logic             busy;
   logic             done_pulse;
   logic             irq;
   logic             err;

   modport slave (
      input  start, cfg_num, abort, irq_clr, finish,
      output enable, clear, total_num, busy, done_pulse, irq, err
   );

   modport master (
      output start, cfg_num, abort, irq_clr, finish,
      input  enable, clear, total_num, busy, done_pulse, irq, err
   );

endinterface

// File: rtl/sfu_job_watchdog.sv
// sfu_job_watchdog: RUN-cycle counter with expiry compare.
//   clk, rstn : clock, asynchronous active-low reset
//   clr       : restart count (asserted the cycle before RUN is entered)
//   run       : controller is in RUN this cycle
//   expired   : this RUN cycle is the TIMEOUT_CYCLES-th without finish
// Only instantiated when SFU_JOB_TIMEOUT_EN is defined.
module sfu_job_watchdog
   import sfu_job_pkg::*;
#(
   parameter int          NUM_W          = NUM_W_DEF,
   parameter logic [31:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic run,
   output logic expired
);

   // count holds the number of RUN cycles already completed, so the last
   // permitted RUN cycle is the one where count equals limit-1.
   localparam logic [NUM_W-1:0] LAST = NUM_W'(TIMEOUT_CYCLES - 32'd1);

   logic [NUM_W-1:0] count;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (run) begin
         count <= count + 1'b1;
      end
   end

   assign expired = run && (count == LAST);

endmodule

// File: rtl/sfu_job_ctrl.sv
// sfu_job_ctrl: per-job sequencer sitting upstream of finish_gen.
//   clk  : system clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : sfu_job_ctrl_if.slave (start/cfg_num/abort/irq_clr/finish in,
//          enable/clear/total_num/busy/done_pulse/irq/err out)
// Sequence: IDLE -> CLEAR (pulse finish_gen clear) -> ARM (enable, finish
// ignored while finish_gen settles) -> RUN (until finish) -> DONE (done
// pulse, sticky irq) -> IDLE. Zero-length jobs go straight to DONE.
// Optional: SFU_JOB_TIMEOUT_EN adds a RUN watchdog that ends the job with a
// sticky err; without it err stays 0 and RUN waits indefinitely.
module sfu_job_ctrl
   import sfu_job_pkg::*;
#(
   parameter int          NUM_W          = NUM_W_DEF,
   parameter logic [31:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic          clk,
   input  logic          rstn,
   sfu_job_ctrl_if.slave bus
);

   state_t           state;
   logic             enable_q;
   logic             clear_q;
   logic             busy_q;
   logic             done_q;
   logic             irq_q;
   logic             err_q;
   logic [NUM_W-1:0] total_q;
   logic             expired;

`ifdef SFU_JOB_TIMEOUT_EN
   sfu_job_watchdog #(
      .NUM_W          (NUM_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (state == ARM),
      .run     (state == RUN),
      .expired (expired)
   );
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign expired        = 1'b0;
`endif

   // Single registered FSM. clear and done_pulse default low so they are
   // one-cycle strobes. irq_clr is applied first so a DONE entry in the same
   // cycle overrides it (set wins).
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         enable_q <= 1'b0;
         clear_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         irq_q    <= 1'b0;
         err_q    <= 1'b0;
         total_q  <= '0;
      end else begin
         clear_q <= 1'b0;
         done_q  <= 1'b0;
         if (bus.irq_clr) begin
            irq_q <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  total_q <= bus.cfg_num;
                  err_q   <= 1'b0;
                  if (bus.cfg_num != '0) begin
                     state   <= CLEAR;
                     clear_q <= 1'b1;
                     busy_q  <= 1'b1;
                  end else begin
                     state  <= DONE;
                     done_q <= 1'b1;
                     irq_q  <= 1'b1;
                  end
               end
            end

            CLEAR: begin
               if (bus.abort) begin
                  state    <= IDLE;
                  enable_q <= 1'b0;
                  busy_q   <= 1'b0;
               end else begin
                  state    <= ARM;
                  enable_q <= 1'b1;
               end
            end

            ARM: begin
               if (bus.abort) begin
                  state    <= IDLE;
                  enable_q <= 1'b0;
                  busy_q   <= 1'b0;
               end else begin
                  state <= RUN;
               end
            end

            // abort beats finish; finish beats watchdog expiry
            RUN: begin
               if (bus.abort) begin
                  state    <= IDLE;
                  enable_q <= 1'b0;
                  busy_q   <= 1'b0;
               end else if (bus.finish || expired) begin
                  state    <= DONE;
                  enable_q <= 1'b0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  irq_q    <= 1'b1;
                  err_q    <= !bus.finish;
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state    <= IDLE;
               enable_q <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.enable     = enable_q;
   assign bus.clear      = clear_q;
   assign bus.total_num  = total_q;
   assign bus.busy       = busy_q;
   assign bus.done_pulse = done_q;
   assign bus.irq        = irq_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_sfu_job_ctrl.sv
// tb_sfu_job_ctrl: self-checking bench for sfu_job_ctrl.
// A small finish_gen model counts enable beats after clear and raises finish
// when the count equals total_num. Expected completions are queued when a
// job is started and compared when done_pulse appears. Build with
// SFU_JOB_TIMEOUT_EN defined to also exercise the watchdog (limit 16).
module tb_sfu_job_ctrl;
   import sfu_job_pkg::*;

   localparam int NUM_W = 32;

   typedef struct {
      logic [NUM_W-1:0] total;
      logic             err;
      int               en_cycles;
   } exp_t;

   typedef struct {
      logic [NUM_W-1:0] cfg;
      int               abort_cyc;
      logic             exp_done;
   } vec_t;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   sfu_job_ctrl_if #(.NUM_W(NUM_W)) bus ();

   sfu_job_ctrl #(
      .NUM_W          (NUM_W),
      .TIMEOUT_CYCLES (32'd16)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   // finish_gen model: clear resets the count, enable advances it.
   logic [NUM_W-1:0] mdl_cnt = '0;
   logic             mdl_off = 1'b0;
   logic             fin_force = 1'b0;

   always @(posedge clk) begin
      if (bus.clear) begin
         mdl_cnt <= '0;
      end else if (bus.enable) begin
         mdl_cnt <= mdl_cnt + 1'b1;
      end
   end

   assign bus.finish = fin_force | (!mdl_off && (mdl_cnt == bus.total_num));

   exp_t sb[$];
   int   checks     = 0;
   int   errors     = 0;
   int   done_count = 0;
   int   en_cnt     = 0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: pop one expected record per done_pulse; count enable-high
   // cycles of the current job (reset whenever the controller is idle).
   always @(negedge clk) begin : monitor
      exp_t e;
      if (bus.done_pulse) begin
         done_count++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done: got done_pulse=1 expected no completion");
         end else begin
            e = sb.pop_front();
            check_output("done_total_num", bus.total_num, e.total);
            check_output("done_err", {31'd0, bus.err}, {31'd0, e.err});
            check_output("done_irq", {31'd0, bus.irq}, 32'd1);
            check_output("done_enable_cycles", en_cnt, e.en_cycles);
         end
      end
      if (!bus.busy && !bus.done_pulse) begin
         en_cnt = 0;
      end else if (bus.enable) begin
         en_cnt++;
      end
   end

   task automatic wait_done(input int dc0, input string name);
      int n;
      n = 0;
      while (done_count == dc0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_output(name, done_count - dc0, 32'd1);
   endtask

   task automatic pulse_irq_clr();
      @(negedge clk);
      bus.irq_clr = 1'b1;
      @(negedge clk);
      bus.irq_clr = 1'b0;
      check_output("irq_cleared", {31'd0, bus.irq}, 32'd0);
   endtask

   // One table entry: start a job, optionally abort after abort_cyc cycles.
   task automatic apply_stimulus(input vec_t v);
      int dc0;
      pulse_irq_clr();
      dc0         = done_count;
      bus.start   = 1'b1;
      bus.cfg_num = v.cfg;
      if (v.exp_done) begin
         sb.push_back('{total: v.cfg, err: 1'b0,
                        en_cycles: (v.cfg == 0) ? 0 : int'(v.cfg) + 1});
      end
      @(negedge clk);
      bus.start = 1'b0;
      check_output("start_total_num", bus.total_num, v.cfg);
      check_output("start_enable", {31'd0, bus.enable}, 32'd0);
      if (v.cfg != 0) begin
         check_output("start_clear", {31'd0, bus.clear}, 32'd1);
         check_output("start_busy", {31'd0, bus.busy}, 32'd1);
      end else begin
         check_output("zero_clear", {31'd0, bus.clear}, 32'd0);
         check_output("zero_done", {31'd0, bus.done_pulse}, 32'd1);
      end
      if (v.abort_cyc > 0) begin
         repeat (v.abort_cyc - 1) @(negedge clk);
         bus.abort = 1'b1;
         @(negedge clk);
         bus.abort = 1'b0;
         check_output("abort_busy", {31'd0, bus.busy}, 32'd0);
         check_output("abort_enable", {31'd0, bus.enable}, 32'd0);
         check_output("abort_clear", {31'd0, bus.clear}, 32'd0);
         repeat (3) @(negedge clk);
         check_output("abort_irq", {31'd0, bus.irq}, 32'd0);
         check_output("abort_no_done", done_count - dc0, 32'd0);
      end else begin
         wait_done(dc0, "job_done_seen");
         @(negedge clk);
         check_output("post_done_irq", {31'd0, bus.irq}, 32'd1);
         check_output("post_done_busy", {31'd0, bus.busy}, 32'd0);
         check_output("post_done_enable", {31'd0, bus.enable}, 32'd0);
      end
   endtask

   initial begin : global_limit
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "[TB] aborted");
   end

   initial begin : stim
      vec_t vecs[7];
      int   dc0;
      int   n;

      vecs[0] = '{cfg: 32'd5, abort_cyc: 0, exp_done: 1'b1};
      vecs[1] = '{cfg: 32'd0, abort_cyc: 0, exp_done: 1'b1};
      vecs[2] = '{cfg: 32'd1, abort_cyc: 0, exp_done: 1'b1};
      vecs[3] = '{cfg: 32'd3, abort_cyc: 1, exp_done: 1'b0};
      vecs[4] = '{cfg: 32'd4, abort_cyc: 2, exp_done: 1'b0};
      vecs[5] = '{cfg: 32'd6, abort_cyc: 4, exp_done: 1'b0};
      vecs[6] = '{cfg: 32'd2, abort_cyc: 0, exp_done: 1'b1};

      rstn        = 1'b0;
      bus.start   = 1'b0;
      bus.cfg_num = '0;
      bus.abort   = 1'b0;
      bus.irq_clr = 1'b0;
      repeat (3) @(negedge clk);
      check_output("rst_enable", {31'd0, bus.enable}, 32'd0);
      check_output("rst_clear", {31'd0, bus.clear}, 32'd0);
      check_output("rst_total_num", bus.total_num, 32'd0);
      check_output("rst_busy", {31'd0, bus.busy}, 32'd0);
      check_output("rst_done", {31'd0, bus.done_pulse}, 32'd0);
      check_output("rst_irq", {31'd0, bus.irq}, 32'd0);
      check_output("rst_err", {31'd0, bus.err}, 32'd0);
      rstn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         apply_stimulus(vecs[i]);
      end

      // cfg=8: second start during RUN ignored, then abort together with finish
      pulse_irq_clr();
      dc0         = done_count;
      bus.start   = 1'b1;
      bus.cfg_num = 32'd8;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      bus.start   = 1'b1;
      bus.cfg_num = 32'd99;
      @(negedge clk);
      bus.start = 1'b0;
      check_output("busy_start_total_num", bus.total_num, 32'd8);
      check_output("busy_start_busy", {31'd0, bus.busy}, 32'd1);
      n = 0;
      while (!bus.finish && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_output("finish_in_run", {31'd0, bus.finish}, 32'd1);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check_output("abort_finish_busy", {31'd0, bus.busy}, 32'd0);
      check_output("abort_finish_enable", {31'd0, bus.enable}, 32'd0);
      check_output("abort_finish_done", {31'd0, bus.done_pulse}, 32'd0);
      repeat (3) @(negedge clk);
      check_output("abort_finish_irq", {31'd0, bus.irq}, 32'd0);
      check_output("abort_finish_total", bus.total_num, 32'd8);
      check_output("abort_finish_no_done", done_count - dc0, 32'd0);

      // irq_clr coinciding with DONE entry: set wins; next cycle it clears
      bus.start   = 1'b1;
      bus.cfg_num = 32'd0;
      bus.irq_clr = 1'b1;
      sb.push_back('{total: 32'd0, err: 1'b0, en_cycles: 0});
      @(negedge clk);
      bus.start = 1'b0;
      check_output("irq_set_wins", {31'd0, bus.irq}, 32'd1);
      @(negedge clk);
      bus.irq_clr = 1'b0;
      check_output("irq_clr_next", {31'd0, bus.irq}, 32'd0);

      // start and abort together in IDLE: start ignored
      dc0         = done_count;
      bus.start   = 1'b1;
      bus.abort   = 1'b1;
      bus.cfg_num = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check_output("start_abort_busy", {31'd0, bus.busy}, 32'd0);
      check_output("start_abort_clear", {31'd0, bus.clear}, 32'd0);
      check_output("start_abort_total", bus.total_num, 32'd0);
      @(negedge clk);
      check_output("start_abort_no_done", done_count - dc0, 32'd0);

      // set irq with a short job, then reset in the middle of a long job
      dc0         = done_count;
      bus.start   = 1'b1;
      bus.cfg_num = 32'd1;
      sb.push_back('{total: 32'd1, err: 1'b0, en_cycles: 2});
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(dc0, "pre_reset_done");
      @(negedge clk);
      bus.start   = 1'b1;
      bus.cfg_num = 32'd10;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      check_output("pre_reset_state_run", 32'(dut.state), 32'(RUN));
      #2;
      rstn = 1'b0;
      #1;
      check_output("async_rst_enable", {31'd0, bus.enable}, 32'd0);
      check_output("async_rst_busy", {31'd0, bus.busy}, 32'd0);
      check_output("async_rst_irq", {31'd0, bus.irq}, 32'd0);
      check_output("async_rst_total", bus.total_num, 32'd0);
      check_output("async_rst_state", 32'(dut.state), 32'(IDLE));
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstn      = 1'b1;
      dc0       = done_count;
      fin_force = 1'b1;
      repeat (3) @(negedge clk);
      fin_force = 1'b0;
      check_output("stale_finish_busy", {31'd0, bus.busy}, 32'd0);
      check_output("stale_finish_no_done", done_count - dc0, 32'd0);
      check_output("stale_finish_irq", {31'd0, bus.irq}, 32'd0);

`ifdef SFU_JOB_TIMEOUT_EN
      // finish never comes: 16 RUN cycles then DONE with err
      mdl_off     = 1'b1;
      dc0         = done_count;
      bus.start   = 1'b1;
      bus.cfg_num = 32'd20;
      sb.push_back('{total: 32'd20, err: 1'b1, en_cycles: 17});
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(dc0, "timeout_done_seen");
      @(negedge clk);
      check_output("timeout_err", {31'd0, bus.err}, 32'd1);
      check_output("timeout_irq", {31'd0, bus.irq}, 32'd1);
      mdl_off     = 1'b0;
      bus.start   = 1'b1;
      bus.cfg_num = 32'd0;
      sb.push_back('{total: 32'd0, err: 1'b0, en_cycles: 0});
      @(negedge clk);
      bus.start = 1'b0;
      check_output("err_cleared_by_start", {31'd0, bus.err}, 32'd0);
      @(negedge clk);
`endif

      repeat (2) @(negedge clk);
      check_output("scoreboard_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
